// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader.
// Holds the FSM state encodings and the default debounce hold time.
package operand_loader_pkg;

    // FSM state encodings. These values also appear directly on state_led.
    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        READY  = 2'b10
    } state_t;

    // Default debounce time: 10 ms at 100 MHz.
    localparam int DB_CYCLES_DEFAULT = 1000000;
    localparam int CNT_W_DEFAULT     = 20;

endpackage

// File: rtl/operand_loader_btn_debounce.sv
// btn_debounce: conditions one raw push-button input.
// The raw level goes through a 2-flop synchronizer, then a debouncer, then a
// rising-edge detector.
// Ports:
//   clk   - system clock
//   rst   - asynchronous, active-high reset
//   btn   - raw, bouncy button level (asynchronous to clk)
//   press - one-cycle pulse for each accepted press
module btn_debounce #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_q;
    logic [CNT_W-1:0] cnt;
    // vld1/vld2 show when sync2 holds a real sample instead of its reset value.
    logic             vld1;
    logic             vld2;
    // armed stays low until the button has been seen released after reset.
    // A button held through reset therefore gives no press until it is
    // released and pressed again.
    logic             armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
            vld1     <= 1'b0;
            vld2     <= 1'b0;
            armed    <= 1'b0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            vld1     <= 1'b1;
            vld2     <= vld1;
            stable_q <= stable;
            if (vld2 && !sync2) begin
                armed <= 1'b1;
            end
            if (sync2 != stable) begin
                if (cnt == CNT_W'(DB_CYCLES)) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = stable & ~stable_q & armed;

endmodule

// File: rtl/operand_loader.sv
// operand_loader: loads two 4-bit operands (A, then B) from slide switches
// using a debounced load button. A debounced clear button resets the pair.
// Ports:
//   clk       - system clock
//   rst       - asynchronous, active-high reset
//   sw[3:0]   - operand value, sampled only on an accepted load press
//   btn_load  - raw load button
//   btn_clr   - raw clear button
//   a_out     - captured operand A
//   b_out     - captured operand B
//   ops_valid - high while both operands are loaded (READY)
//   ops_new   - one-cycle pulse after the edge where B is captured
//   led       - {a_out, b_out}
//   state_led - current state encoding
//
// state  | meaning
// -------+------------------------------------------------------------
// WAIT_A | waiting for a load press to capture A
// WAIT_B | A captured, waiting for a load press to capture B
// READY  | both operands valid; a load press starts a new pair
// 2'b11  | illegal, returns to WAIT_A on the next edge
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_load,
    input  logic       btn_clr,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    output logic       ops_valid,
    output logic       ops_new,
    output logic [7:0] led,
    output logic [1:0] state_led
);

    logic       load_p;
    logic       clr_p;
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [3:0] a_q;
    logic [3:0] a_d;
    logic [3:0] b_q;
    logic [3:0] b_d;
    logic       new_q;
    logic       new_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_load (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_load),
        .press (load_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_clr (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clr),
        .press (clr_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            new_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            new_q   <= new_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        new_d   = 1'b0;
        // If both presses arrive together, clear wins and the load is dropped.
        if (clr_p) begin
            state_d = WAIT_A;
            a_d     = '0;
            b_d     = '0;
        end else begin
            case (state_q)
                WAIT_A: begin
                    if (load_p) begin
                        a_d     = sw;
                        state_d = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (load_p) begin
                        b_d     = sw;
                        new_d   = 1'b1;
                        state_d = READY;
                    end
                end
                READY: begin
                    if (load_p) begin
                        a_d     = sw;
                        b_d     = '0;
                        state_d = WAIT_B;
                    end
                end
                default: begin
                    // Recovery from the illegal encoding; also drop any partial pair.
                    state_d = WAIT_A;
                    a_d     = '0;
                    b_d     = '0;
                end
            endcase
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign ops_new   = new_q;
    assign ops_valid = (state_q == READY);
    assign led       = {a_q, b_q};
    assign state_led = state_q;

endmodule
